// File: rtl/rca_32_adder.sv
// Ripple-carry adder with a registered result.
// {Cout,SUM} = A + B + Cin (unsigned, WIDTH+1 bits), valid one clock after the operands.
// The sum path is a plain chain of full-adder cells so this adder can serve as the
// slow, obviously-correct baseline that faster adders are compared against.

// One-bit full adder: the only place where sum and carry logic lives.
module FullAdderCell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Sum is the parity of the three inputs; carry is their majority.
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module rca_32_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
);

    // carry[i] enters bit i; carry[WIDTH] is the carry out of the top bit.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = Cin;

    // Strict ripple: each cell waits on the carry of the cell below it, no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        FullAdderCell u_cell (
            .a_i (A[i]),
            .b_i (B[i]),
            .c_i (carry[i]),
            .s_o (sum_d[i]),
            .c_o (carry[i+1])
        );
    end

    // Capture the combinational result each cycle; reset clears both outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= carry[WIDTH];
        end
    end

    assign SUM  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_rca_32_adder.sv
// Testbench for rca_32_adder: directed corner cases, reset behaviour and a long
// random run, each result compared against a plain-arithmetic model of A + B + Cin.
module tb_rca_32_adder;

    localparam int WIDTH = 32;
    localparam int RANDOM_COUNT = 10000;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] SUM;
    logic             Cout;

    int checkCount;
    int failCount;

    rca_32_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .SUM  (SUM),
        .Cout (Cout)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact (WIDTH+1)-bit unsigned sum.
    function automatic logic [WIDTH:0] modelSum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin);
        logic [WIDTH:0] result;
        result = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        return result;
    endfunction

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag,
                               input logic [WIDTH:0] observed,
                               input logic [WIDTH:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got {Cout,SUM}=%h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one operand set, let one rising edge capture it, then settle past the edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic cin,
                                 input logic rstIn);
        A   = a;
        B   = b;
        Cin = cin;
        rst = rstIn;
        @(posedge clk);
        #1;
    endtask

    // Apply operands without reset and check the registered result against the model.
    task automatic addAndCheck(input string tag,
                               input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b,
                               input logic cin);
        applyStimulus(a, b, cin, 1'b0);
        checkOutput(tag, {Cout, SUM}, modelSum(a, b, cin));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        checkCount = 0;
        failCount  = 0;
        A   = '0;
        B   = '0;
        Cin = 1'b0;
        rst = 1'b1;

        // Reset state after the first edge with rst high.
        applyStimulus('0, '0, 1'b0, 1'b1);
        checkOutput("reset_initial", {Cout, SUM}, 33'h0);

        // Directed cases, back to back on consecutive cycles.
        addAndCheck("dec_100k_200k", 32'd100000, 32'd200000, 1'b0);
        checkOutput("const_300000", {Cout, SUM}, {1'b0, 32'h000493E0});
        addAndCheck("ones_plus_1", 32'hFFFFFFFF, 32'h1, 1'b0);
        checkOutput("const_full_ripple", {Cout, SUM}, {1'b1, 32'h0});
        addAndCheck("dec_cin1", 32'd12345678, 32'd87654321, 1'b1);
        checkOutput("const_100M", {Cout, SUM}, {1'b0, 32'h05F5E100});
        addAndCheck("zero_ones_cin", 32'h0, 32'hFFFFFFFF, 1'b1);
        checkOutput("const_cin_ripple", {Cout, SUM}, {1'b1, 32'h0});
        addAndCheck("cin_only", 32'h0, 32'h0, 1'b1);
        addAndCheck("cin_increment", 32'h7FFFFFFF, 32'h0, 1'b1);
        addAndCheck("max_max_cin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        addAndCheck("alt_bits", 32'hAAAAAAAA, 32'h55555555, 1'b1);

        // Reset mid-stream overrides a result that would otherwise be all ones plus carry.
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        checkOutput("reset_override", {Cout, SUM}, 33'h0);
        addAndCheck("after_reset", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        checkOutput("const_after_reset", {Cout, SUM}, {1'b1, 32'hFFFFFFFE});
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        checkOutput("reset_again", {Cout, SUM}, 33'h0);
        addAndCheck("release_ones_cin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        checkOutput("const_release", {Cout, SUM}, {1'b1, 32'hFFFFFFFF});

        // Random operands, a new set every cycle.
        for (int i = 0; i < RANDOM_COUNT; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            addAndCheck("random", ra, rb, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
